// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, ALU CSR register map and default widths.
// The ALU's APB slave imports the same register constants.
package apb_pkg;

  localparam int APB_ADDRESS_SIZE = 2;
  localparam int APB_DATA_WIDTH   = 32;

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_0    = 2'd1;
  localparam logic [1:0] REG_1    = 2'd2;
  localparam logic [1:0] REG_RES  = 2'd3;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-cycle counter for the APB master's ACCESS timeout.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at the limit so a stalled count can never wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns single-word local commands into SETUP/ACCESS transfers and
// returns a one-cycle response pulse. Optional ACCESS timeout via APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDRESS_SIZE   = APB_ADDRESS_SIZE,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS_SIZE-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic [ADDRESS_SIZE-1:0] addr,
  output logic                    sel,
  output logic                    en,
  output logic                    write,
  output logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    ready,
  input  logic                    slv_err,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout
);

  logic [1:0]              state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    sel_q, sel_d;
  logic                    en_q, en_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic cnt_expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == APB_SETUP),
    .inc    ((state_q == APB_ACCESS) && !ready),
    .expired(cnt_expired)
  );

  assign timeout_hit = cnt_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == APB_IDLE);

  // sel/en are registered, so they are derived from the next state.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      APB_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_wdata;
          state_d = APB_SETUP;
        end
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        // A late ready in the abort cycle still wins over the timeout.
        if (ready) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = slv_err;
          rsp_rdata_d   = (!write_q && !slv_err) ? rdata : '0;
          rsp_timeout_d = 1'b0;
          state_d       = APB_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = APB_IDLE;
        end
      end
      default: begin
        state_d = APB_IDLE;
      end
    endcase
    sel_d = (state_d != APB_IDLE);
    en_d  = (state_d == APB_ACCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= APB_IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      sel_q         <= 1'b0;
      en_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      sel_q         <= sel_d;
      en_q          <= en_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign addr        = addr_q;
  assign write       = write_q;
  assign wdata       = wdata_q;
  assign sel         = sel_q;
  assign en          = en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master; the slave side is driven by hand, one cycle at a time.
// Build with APB_MASTER_TIMEOUT_EN to exercise the timeout abort instead of the endless wait.
module tb_apb_master;
  import apb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [1:0]  cmdAddr;
  logic [31:0] cmdWdata;
  logic [1:0]  apbAddr;
  logic        apbSel;
  logic        apbEn;
  logic        apbWrite;
  logic [31:0] apbWdata;
  logic [31:0] apbRdata;
  logic        apbReady;
  logic        apbSlvErr;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        rspTimeout;

  int nAsserts = 0;
  int nFails   = 0;

  apb_master #(
    .ADDRESS_SIZE  (2),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmdValid),
    .cmd_ready  (cmdReady),
    .cmd_write  (cmdWrite),
    .cmd_addr   (cmdAddr),
    .cmd_wdata  (cmdWdata),
    .addr       (apbAddr),
    .sel        (apbSel),
    .en         (apbEn),
    .write      (apbWrite),
    .wdata      (apbWdata),
    .rdata      (apbRdata),
    .ready      (apbReady),
    .slv_err    (apbSlvErr),
    .rsp_valid  (rspValid),
    .rsp_rdata  (rspRdata),
    .rsp_err    (rspErr),
    .rsp_timeout(rspTimeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic wr,
                               input logic [1:0] a, input logic [31:0] d);
    cmdValid = valid;
    cmdWrite = wr;
    cmdAddr  = a;
    cmdWdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    apbRdata  = '0;
    apbReady  = 1'b0;
    apbSlvErr = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    tick();
    checkOutput("rst_sel", 32'(apbSel), 32'd0);
    checkOutput("rst_en", 32'(apbEn), 32'd0);
    checkOutput("rst_write", 32'(apbWrite), 32'd0);
    checkOutput("rst_addr", 32'(apbAddr), 32'd0);
    checkOutput("rst_wdata", apbWdata, 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_rsp_rdata", rspRdata, 32'd0);
    checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("rst_rsp_timeout", 32'(rspTimeout), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("[TB] zero-wait write 0x5 to REG_0");
    applyStimulus(1'b1, 1'b1, REG_0, 32'h5);
    apbReady = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("wr_c1_sel", 32'(apbSel), 32'd1);
    checkOutput("wr_c1_en", 32'(apbEn), 32'd0);
    checkOutput("wr_c1_cmd_ready", 32'(cmdReady), 32'd0);
    checkOutput("wr_c1_addr", 32'(apbAddr), 32'(REG_0));
    checkOutput("wr_c1_write", 32'(apbWrite), 32'd1);
    checkOutput("wr_c1_wdata", apbWdata, 32'h5);
    tick();
    checkOutput("wr_c2_sel", 32'(apbSel), 32'd1);
    checkOutput("wr_c2_en", 32'(apbEn), 32'd1);
    checkOutput("wr_c2_rsp_valid", 32'(rspValid), 32'd0);
    tick();
    apbReady = 1'b0;
    checkOutput("wr_c3_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("wr_c3_sel", 32'(apbSel), 32'd0);
    checkOutput("wr_c3_en", 32'(apbEn), 32'd0);
    checkOutput("wr_c3_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("wr_c3_rsp_rdata", rspRdata, 32'd0);
    checkOutput("wr_c3_cmd_ready", 32'(cmdReady), 32'd1);
    tick();
    checkOutput("wr_c4_rsp_valid", 32'(rspValid), 32'd0);

    $display("[TB] read REG_RES with one wait cycle");
    applyStimulus(1'b1, 1'b0, REG_RES, 32'hFFFF_FFFF);
    apbRdata = 32'hA5;
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    checkOutput("rd_c2_en", 32'(apbEn), 32'd1);
    checkOutput("rd_c2_addr", 32'(apbAddr), 32'(REG_RES));
    checkOutput("rd_c2_write", 32'(apbWrite), 32'd0);
    tick();
    checkOutput("rd_c3_en", 32'(apbEn), 32'd1);
    checkOutput("rd_c3_rsp_valid", 32'(rspValid), 32'd0);
    apbReady = 1'b1;
    tick();
    apbReady = 1'b0;
    checkOutput("rd_c4_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("rd_c4_rsp_rdata", rspRdata, 32'hA5);
    checkOutput("rd_c4_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("rd_c4_sel", 32'(apbSel), 32'd0);

    $display("[TB] read REG_CTRL with slave error");
    applyStimulus(1'b1, 1'b0, REG_CTRL, 32'h0);
    apbRdata  = 32'hDEAD_BEEF;
    apbReady  = 1'b1;
    apbSlvErr = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    tick();
    apbReady  = 1'b0;
    apbSlvErr = 1'b0;
    checkOutput("err_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("err_rsp_err", 32'(rspErr), 32'd1);
    checkOutput("err_rsp_rdata", rspRdata, 32'd0);
    tick();
    checkOutput("err_hold_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("err_hold_rsp_err", 32'(rspErr), 32'd1);

    $display("[TB] back-to-back writes with cmd_valid held");
    applyStimulus(1'b1, 1'b1, REG_1, 32'h11);
    apbReady = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, REG_0, 32'h22);
    tick();
    checkOutput("b2b_a_en", 32'(apbEn), 32'd1);
    checkOutput("b2b_a_wdata_stable", apbWdata, 32'h11);
    checkOutput("b2b_a_addr_stable", 32'(apbAddr), 32'(REG_1));
    tick();
    checkOutput("b2b_gap_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("b2b_gap_sel", 32'(apbSel), 32'd0);
    checkOutput("b2b_gap_cmd_ready", 32'(cmdReady), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("b2b_b_sel", 32'(apbSel), 32'd1);
    checkOutput("b2b_b_en", 32'(apbEn), 32'd0);
    checkOutput("b2b_b_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("b2b_b_wdata", apbWdata, 32'h22);
    checkOutput("b2b_b_addr", 32'(apbAddr), 32'(REG_0));
    tick();
    checkOutput("b2b_b_access_en", 32'(apbEn), 32'd1);
    tick();
    apbReady = 1'b0;
    checkOutput("b2b_b_rsp_valid_end", 32'(rspValid), 32'd1);

`ifdef APB_MASTER_TIMEOUT_EN
    $display("[TB] timeout abort with ready held low");
    applyStimulus(1'b1, 1'b0, REG_0, 32'h0);
    apbRdata = 32'h77;
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("to_last_wait_en", 32'(apbEn), 32'd1);
    checkOutput("to_last_wait_rsp_valid", 32'(rspValid), 32'd0);
    tick();
    checkOutput("to_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("to_rsp_err", 32'(rspErr), 32'd1);
    checkOutput("to_rsp_timeout", 32'(rspTimeout), 32'd1);
    checkOutput("to_rsp_rdata", rspRdata, 32'd0);
    checkOutput("to_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("to_sel", 32'(apbSel), 32'd0);

    $display("[TB] ready arriving in the abort cycle completes normally");
    applyStimulus(1'b1, 1'b0, REG_1, 32'h0);
    apbRdata = 32'h3C;
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    apbReady = 1'b1;
    tick();
    apbReady = 1'b0;
    checkOutput("to_late_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("to_late_rsp_timeout", 32'(rspTimeout), 32'd0);
    checkOutput("to_late_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("to_late_rsp_rdata", rspRdata, 32'h3C);
`else
    $display("[TB] long wait without timeout");
    applyStimulus(1'b1, 1'b0, REG_1, 32'h0);
    apbRdata = 32'h33;
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 21; i++) tick();
    checkOutput("wait_en", 32'(apbEn), 32'd1);
    checkOutput("wait_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("wait_rsp_timeout", 32'(rspTimeout), 32'd0);
    apbReady = 1'b1;
    tick();
    apbReady = 1'b0;
    checkOutput("wait_done_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("wait_done_rsp_rdata", rspRdata, 32'h33);
    checkOutput("wait_done_rsp_timeout", 32'(rspTimeout), 32'd0);
`endif

    $display("[TB] reset asserted during ACCESS");
    applyStimulus(1'b1, 1'b1, REG_0, 32'h99);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    checkOutput("mrst_pre_en", 32'(apbEn), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_async_sel", 32'(apbSel), 32'd0);
    checkOutput("mrst_async_en", 32'(apbEn), 32'd0);
    tick();
    checkOutput("mrst_rsp_valid", 32'(rspValid), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("mrst_after_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("mrst_after_sel", 32'(apbSel), 32'd0);
    checkOutput("mrst_after_rsp_valid", 32'(rspValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
